// File: rtl/eq_training_sequencer.sv
// rtl/eq_training_sequencer.sv - two-gear LMS training sequencer with coefficient snapshot/restore
module eq_training_sequencer #(
  parameter int NUM_TAPS     = 11,
  parameter int COEF_WIDTH   = 16,
  parameter int RD_LAT       = 2,
  parameter int HOLD_SAMPLES = 32
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_start,
  input  logic                  i_abort,
  input  logic                  i_restore_req,
  input  logic                  i_sample_valid,
  input  logic [15:0]           i_eq_error_power,
  input  logic                  i_eq_converged,
  input  logic [COEF_WIDTH-1:0] i_eq_coef_rdata,
  output logic                  o_eq_training_mode,
  output logic                  o_eq_freeze_coefs,
  output logic [7:0]            o_eq_step_size,
  output logic                  o_eq_coef_read,
  output logic                  o_eq_coef_write,
  output logic [3:0]            o_eq_coef_addr,
  output logic [COEF_WIDTH-1:0] o_eq_coef_wdata,
  input  logic [7:0]            i_cfg_step_coarse,
  input  logic [7:0]            i_cfg_step_fine,
  input  logic [15:0]           i_cfg_coarse_len,
  input  logic [15:0]           i_cfg_power_thresh,
  input  logic [15:0]           i_cfg_max_samples,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_fail,
  output logic                  o_snapshot_valid,
  output logic [2:0]            o_state_out,
  output logic [15:0]           o_train_count
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_COARSE  = 3'd1,
    S_FINE    = 3'd2,
    S_HOLD    = 3'd3,
    S_SNAP    = 3'd4,
    S_DONE    = 3'd5,
    S_FAIL    = 3'd6,
    S_RESTORE = 3'd7
  } state_t;

  localparam logic [3:0]  LAST_ADDR = 4'(NUM_TAPS - 1);
  localparam logic [3:0]  LAT_END   = 4'(RD_LAT);
  localparam logic [15:0] HOLD_END  = 16'(HOLD_SAMPLES);

  state_t                r_state, r_ret_state;
  logic                  r_training, r_freeze, r_read, r_write;
  logic [7:0]            r_step;
  logic [3:0]            r_addr, r_lat;
  logic [COEF_WIDTH-1:0] r_wdata;
  logic                  r_busy, r_done, r_fail, r_snap_valid;
  logic [15:0]           r_train_count, r_phase_cnt, r_hold_cnt, r_to_cnt;
  logic [COEF_WIDTH-1:0] r_bank [NUM_TAPS];

  state_t      w_state_nxt, w_ret_nxt;
  logic [7:0]  w_step_nxt;
  logic [15:0] w_phase_nxt, w_hold_nxt, w_to_nxt, w_tc_nxt;
  logic [15:0] w_phase_inc, w_hold_inc;
  logic [3:0]  w_lat_nxt, w_addr_nxt;
  logic        w_capture, w_done_nxt, w_fail_nxt, w_snapv_nxt, w_timeout;
  logic        w_train_nxt, w_access_nxt;

  assign o_eq_training_mode = r_training;
  assign o_eq_freeze_coefs  = r_freeze;
  assign o_eq_step_size     = r_step;
  assign o_eq_coef_read     = r_read;
  assign o_eq_coef_write    = r_write;
  assign o_eq_coef_addr     = r_addr;
  assign o_eq_coef_wdata    = r_wdata;
  assign o_busy             = r_busy;
  assign o_done             = r_done;
  assign o_fail             = r_fail;
  assign o_snapshot_valid   = r_snap_valid;
  assign o_state_out        = r_state;
  assign o_train_count      = r_train_count;

  assign w_phase_inc  = r_phase_cnt + 16'd1;
  assign w_hold_inc   = r_hold_cnt + 16'd1;
  assign w_timeout    = (i_cfg_max_samples != 16'd0) && ((r_to_cnt + 16'd1) >= i_cfg_max_samples);
  assign w_train_nxt  = (w_state_nxt == S_COARSE) || (w_state_nxt == S_FINE) || (w_state_nxt == S_HOLD);
  assign w_access_nxt = (w_state_nxt == S_SNAP) || (w_state_nxt == S_RESTORE);

  always_comb begin
    w_state_nxt = r_state;
    w_ret_nxt   = r_ret_state;
    w_step_nxt  = r_step;
    w_phase_nxt = r_phase_cnt;
    w_hold_nxt  = r_hold_cnt;
    w_to_nxt    = r_to_cnt;
    w_lat_nxt   = r_lat;
    w_addr_nxt  = r_addr;
    w_capture   = 1'b0;
    w_done_nxt  = r_done;
    w_fail_nxt  = r_fail;
    w_snapv_nxt = r_snap_valid;
    w_tc_nxt    = r_train_count;
    if (r_training && i_sample_valid && (r_train_count != 16'hFFFF))
      w_tc_nxt = r_train_count + 16'd1;

    case (r_state)
      S_IDLE, S_DONE, S_FAIL: begin
        // abort outranks restore and start even where it has nothing to stop
        if (!i_abort) begin
          if (i_restore_req && r_snap_valid) begin
            w_state_nxt = S_RESTORE;
            w_ret_nxt   = r_state;
            w_lat_nxt   = 4'd0;
            w_addr_nxt  = 4'd0;
          end else if (i_start) begin
            w_state_nxt = S_COARSE;
            w_step_nxt  = i_cfg_step_coarse;
            w_done_nxt  = 1'b0;
            w_fail_nxt  = 1'b0;
            w_tc_nxt    = 16'd0;
            w_phase_nxt = 16'd0;
          end
        end
      end
      S_COARSE: begin
        if (i_abort) begin
          w_state_nxt = S_FAIL;
          w_fail_nxt  = 1'b1;
        end else if (i_sample_valid) begin
          w_phase_nxt = w_phase_inc;
          if ((w_phase_inc >= i_cfg_coarse_len) || (i_eq_error_power < i_cfg_power_thresh)) begin
            w_state_nxt = S_FINE;
            w_step_nxt  = i_cfg_step_fine;
            w_phase_nxt = 16'd0;
            w_hold_nxt  = 16'd0;
            w_to_nxt    = 16'd0;
          end
        end
      end
      S_FINE, S_HOLD: begin
        if (i_abort) begin
          w_state_nxt = S_FAIL;
          w_fail_nxt  = 1'b1;
        end else if (i_sample_valid) begin
          w_to_nxt = r_to_cnt + 16'd1;
          if (i_eq_converged) begin
            w_hold_nxt = w_hold_inc;
            // completing the hold beats a simultaneous timeout
            if (w_hold_inc >= HOLD_END) begin
              w_state_nxt = S_SNAP;
              w_hold_nxt  = 16'd0;
              w_lat_nxt   = 4'd0;
              w_addr_nxt  = 4'd0;
              w_snapv_nxt = 1'b0;
            end else if (w_timeout) begin
              w_state_nxt = S_FAIL;
              w_fail_nxt  = 1'b1;
            end else begin
              w_state_nxt = S_HOLD;
            end
          end else begin
            w_hold_nxt = 16'd0;
            if (w_timeout) begin
              w_state_nxt = S_FAIL;
              w_fail_nxt  = 1'b1;
            end else begin
              w_state_nxt = S_FINE;
              w_step_nxt  = i_cfg_step_fine;
            end
          end
        end
      end
      S_SNAP: begin
        if (i_abort) begin
          w_state_nxt = S_FAIL;
          w_fail_nxt  = 1'b1;
        end else if (r_lat == LAT_END) begin
          w_capture = 1'b1;
          w_lat_nxt = 4'd0;
          if (r_addr == LAST_ADDR) begin
            w_state_nxt = S_DONE;
            w_done_nxt  = 1'b1;
            w_snapv_nxt = 1'b1;
          end else begin
            w_addr_nxt = r_addr + 4'd1;
          end
        end else begin
          w_lat_nxt = r_lat + 4'd1;
        end
      end
      S_RESTORE: begin
        // lat 0 = write cycle, lat 1 = idle cycle
        if (r_lat == 4'd0) begin
          w_lat_nxt = 4'd1;
        end else begin
          w_lat_nxt = 4'd0;
          if (r_addr == LAST_ADDR) w_state_nxt = r_ret_state;
          else                     w_addr_nxt  = r_addr + 4'd1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state       <= S_IDLE;
      r_ret_state   <= S_IDLE;
      r_training    <= 1'b0;
      r_freeze      <= 1'b1;
      r_step        <= 8'd0;
      r_read        <= 1'b0;
      r_write       <= 1'b0;
      r_addr        <= 4'd0;
      r_wdata       <= '0;
      r_lat         <= 4'd0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_fail        <= 1'b0;
      r_snap_valid  <= 1'b0;
      r_train_count <= 16'd0;
      r_phase_cnt   <= 16'd0;
      r_hold_cnt    <= 16'd0;
      r_to_cnt      <= 16'd0;
    end else begin
      r_state       <= w_state_nxt;
      r_ret_state   <= w_ret_nxt;
      r_training    <= w_train_nxt;
      r_freeze      <= !w_train_nxt;
      r_step        <= w_step_nxt;
      r_read        <= (w_state_nxt == S_SNAP) && (w_lat_nxt < LAT_END);
      r_write       <= (w_state_nxt == S_RESTORE) && (w_lat_nxt == 4'd0);
      r_addr        <= w_access_nxt ? w_addr_nxt : 4'd0;
      if ((w_state_nxt == S_RESTORE) && (w_lat_nxt == 4'd0))
        r_wdata <= r_bank[w_addr_nxt];
      r_lat         <= w_lat_nxt;
      r_busy        <= !((w_state_nxt == S_IDLE) || (w_state_nxt == S_DONE) || (w_state_nxt == S_FAIL));
      r_done        <= w_done_nxt;
      r_fail        <= w_fail_nxt;
      r_snap_valid  <= w_snapv_nxt;
      r_train_count <= w_tc_nxt;
      r_phase_cnt   <= w_phase_nxt;
      r_hold_cnt    <= w_hold_nxt;
      r_to_cnt      <= w_to_nxt;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset && w_capture)
      r_bank[r_addr] <= i_eq_coef_rdata;
  end

endmodule

// File: tb/tb_eq_training_sequencer.sv
// tb/tb_eq_training_sequencer.sv - scoreboard bench for eq_training_sequencer
module tb_eq_training_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, start, abort, restore_req, sample_valid, eq_converged;
  logic [15:0] eq_error_power, eq_coef_rdata;
  logic        eq_training_mode, eq_freeze_coefs, eq_coef_read, eq_coef_write;
  logic [7:0]  eq_step_size;
  logic [3:0]  eq_coef_addr;
  logic [15:0] eq_coef_wdata;
  logic [7:0]  cfg_step_coarse, cfg_step_fine;
  logic [15:0] cfg_coarse_len, cfg_power_thresh, cfg_max_samples;
  logic        busy, done, fail, snapshot_valid;
  logic [2:0]  state_out;
  logic [15:0] train_count;

  int n_checks = 0;
  int n_errors = 0;
  logic [2:0]  exp_state_q[$];
  logic [19:0] exp_wr_q[$];

  eq_training_sequencer dut (
    .i_clk(clk), .i_reset(reset), .i_start(start), .i_abort(abort),
    .i_restore_req(restore_req), .i_sample_valid(sample_valid),
    .i_eq_error_power(eq_error_power), .i_eq_converged(eq_converged),
    .i_eq_coef_rdata(eq_coef_rdata),
    .o_eq_training_mode(eq_training_mode), .o_eq_freeze_coefs(eq_freeze_coefs),
    .o_eq_step_size(eq_step_size), .o_eq_coef_read(eq_coef_read),
    .o_eq_coef_write(eq_coef_write), .o_eq_coef_addr(eq_coef_addr),
    .o_eq_coef_wdata(eq_coef_wdata),
    .i_cfg_step_coarse(cfg_step_coarse), .i_cfg_step_fine(cfg_step_fine),
    .i_cfg_coarse_len(cfg_coarse_len), .i_cfg_power_thresh(cfg_power_thresh),
    .i_cfg_max_samples(cfg_max_samples),
    .o_busy(busy), .o_done(done), .o_fail(fail), .o_snapshot_valid(snapshot_valid),
    .o_state_out(state_out), .o_train_count(train_count)
  );

  // equalizer coefficient port: data valid only after addr held with read for exactly two cycles
  logic       s1_rd = 1'b0, s2_rd = 1'b0;
  logic [3:0] s1_addr = 4'd0, s2_addr = 4'd0;
  always @(posedge clk) begin
    s1_rd   <= eq_coef_read;
    s1_addr <= eq_coef_addr;
    s2_rd   <= s1_rd;
    s2_addr <= s1_addr;
  end
  assign eq_coef_rdata = (s1_rd && s2_rd && (s1_addr == s2_addr)) ? (16'h1000 + {12'd0, s2_addr}) : 16'hDEAD;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  logic [2:0]  prev_state = 3'd0;
  logic [2:0]  mon_es;
  logic [19:0] mon_ew;
  always @(negedge clk) begin
    if (!reset) begin
      if (state_out != prev_state) begin
        if (exp_state_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL state_seq: got %0d expected no change from %0d", state_out, prev_state);
        end else begin
          mon_es = exp_state_q.pop_front();
          chk("state_seq", {29'd0, state_out}, {29'd0, mon_es});
        end
      end
      if (eq_coef_write) begin
        chk("rd_wr_exclusive", {31'd0, eq_coef_read}, 32'd0);
        if (exp_wr_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL coef_write: got addr %0d data 0x%0h expected no write", eq_coef_addr, eq_coef_wdata);
        end else begin
          mon_ew = exp_wr_q.pop_front();
          chk("coef_write", {12'd0, eq_coef_addr, eq_coef_wdata}, {12'd0, mon_ew});
        end
      end
    end
    prev_state = state_out;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic smp(input logic [15:0] pw, input logic cv);
    sample_valid   = 1'b1;
    eq_error_power = pw;
    eq_converged   = cv;
    tick();
    sample_valid = 1'b0;
  endtask

  initial begin
    #200000;
    n_errors++;
    $display("FAIL watchdog: got timeout expected finish");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    reset = 1'b1; start = 1'b0; abort = 1'b0; restore_req = 1'b0;
    sample_valid = 1'b0; eq_converged = 1'b0; eq_error_power = 16'd100;
    cfg_step_coarse = 8'd16; cfg_step_fine = 8'd4; cfg_coarse_len = 16'd20;
    cfg_power_thresh = 16'd0; cfg_max_samples = 16'd0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_freeze", {31'd0, eq_freeze_coefs}, 32'd1);
    chk("rst_state", {29'd0, state_out}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_snapv", {31'd0, snapshot_valid}, 32'd0);
    chk("rst_train", {31'd0, eq_training_mode}, 32'd0);
    chk("rst_step", {24'd0, eq_step_size}, 32'd0);
    chk("rst_access", {14'd0, eq_coef_read, eq_coef_write, eq_coef_addr, eq_coef_wdata}, 32'd0);

    // start -> COARSE
    exp_state_q.push_back(3'd1);
    pulse_start();
    chk("start_training", {31'd0, eq_training_mode}, 32'd1);
    chk("start_freeze", {31'd0, eq_freeze_coefs}, 32'd0);
    chk("start_step", {24'd0, eq_step_size}, 32'd16);
    chk("start_busy", {31'd0, busy}, 32'd1);

    // coarse length shift
    exp_state_q.push_back(3'd2);
    repeat (19) smp(16'd100, 1'b0);
    chk("coarse_19", {29'd0, state_out}, 32'd1);
    smp(16'd100, 1'b0);
    chk("fine_after_20", {29'd0, state_out}, 32'd2);
    chk("fine_step", {24'd0, eq_step_size}, 32'd4);
    chk("tc_20", {16'd0, train_count}, 32'd20);

    // hold interrupted after 31, then full 32 -> SNAP -> DONE
    exp_state_q.push_back(3'd3);
    repeat (31) smp(16'd100, 1'b1);
    chk("hold_31a", {29'd0, state_out}, 32'd3);
    exp_state_q.push_back(3'd2);
    smp(16'd100, 1'b0);
    chk("hold_break", {29'd0, state_out}, 32'd2);
    exp_state_q.push_back(3'd3);
    repeat (31) smp(16'd100, 1'b1);
    chk("hold_31b", {29'd0, state_out}, 32'd3);
    exp_state_q.push_back(3'd4);
    smp(16'd100, 1'b1);
    chk("snap_entry", {29'd0, state_out}, 32'd4);
    chk("snap_read0", {27'd0, eq_coef_read, eq_coef_addr}, {27'd0, 1'b1, 4'd0});
    chk("snap_freeze", {30'd0, eq_freeze_coefs, eq_training_mode}, 32'd2);
    chk("tc_84", {16'd0, train_count}, 32'd84);
    exp_state_q.push_back(3'd5);
    repeat (32) tick();
    chk("snap_32cyc", {30'd0, state_out == 3'd4, done}, 32'd2);
    tick();
    chk("done_state", {29'd0, state_out}, 32'd5);
    chk("done_flags", {29'd0, done, snapshot_valid, busy}, 32'd6);

    // restore from DONE with an ignored abort in the middle
    for (int i = 0; i < 11; i++) exp_wr_q.push_back({i[3:0], 16'h1000 + i[15:0]});
    exp_state_q.push_back(3'd7);
    exp_state_q.push_back(3'd5);
    restore_req = 1'b1;
    tick();
    restore_req = 1'b0;
    chk("restore_entry", {27'd0, eq_coef_write, eq_coef_addr}, {27'd0, 1'b1, 4'd0});
    repeat (3) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    repeat (17) tick();
    chk("restore_21", {29'd0, state_out}, 32'd7);
    tick();
    chk("restore_back", {29'd0, state_out}, 32'd5);
    chk("restore_flags", {29'd0, done, fail, snapshot_valid}, 32'd5);
    chk("restore_all_writes", exp_wr_q.size(), 32'd0);

    // early shift on power threshold, then abort during SNAP
    exp_state_q.push_back(3'd1);
    pulse_start();
    chk("restart_flags", {30'd0, done, snapshot_valid}, 32'd1);
    cfg_power_thresh = 16'd50;
    exp_state_q.push_back(3'd2);
    smp(16'd100, 1'b0);
    smp(16'd100, 1'b0);
    chk("thresh_2", {29'd0, state_out}, 32'd1);
    smp(16'd10, 1'b0);
    chk("thresh_fine", {29'd0, state_out}, 32'd2);
    chk("tc_3", {16'd0, train_count}, 32'd3);
    exp_state_q.push_back(3'd3);
    repeat (31) smp(16'd100, 1'b1);
    exp_state_q.push_back(3'd4);
    smp(16'd100, 1'b1);
    chk("snap2_snapv", {31'd0, snapshot_valid}, 32'd0);
    repeat (5) tick();
    exp_state_q.push_back(3'd6);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_state", {29'd0, state_out}, 32'd6);
    chk("abort_flags", {28'd0, fail, snapshot_valid, eq_freeze_coefs, eq_coef_read}, 32'b1010);
    chk("abort_step", {24'd0, eq_step_size}, 32'd4);
    restore_req = 1'b1;
    tick();
    restore_req = 1'b0;
    tick();
    chk("restore_ignored", {30'd0, state_out == 3'd6, eq_coef_write}, 32'd2);

    // timeout after 100 FINE samples
    cfg_power_thresh = 16'd0;
    cfg_max_samples  = 16'd100;
    exp_state_q.push_back(3'd1);
    pulse_start();
    chk("restart_fail_clr", {31'd0, fail}, 32'd0);
    exp_state_q.push_back(3'd2);
    repeat (20) smp(16'd100, 1'b0);
    exp_state_q.push_back(3'd6);
    repeat (99) smp(16'd100, 1'b0);
    chk("fine_99", {29'd0, state_out}, 32'd2);
    smp(16'd100, 1'b0);
    chk("timeout_state", {29'd0, state_out}, 32'd6);
    chk("timeout_flags", {29'd0, fail, eq_freeze_coefs, eq_training_mode}, 32'd6);
    chk("tc_120", {16'd0, train_count}, 32'd120);

    // reset mid-COARSE, then start+abort together in IDLE
    cfg_max_samples = 16'd0;
    exp_state_q.push_back(3'd1);
    pulse_start();
    repeat (5) smp(16'd100, 1'b0);
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    chk("midrst_state", {29'd0, state_out}, 32'd0);
    chk("midrst_flags", {26'd0, eq_freeze_coefs, eq_training_mode, busy, done, fail, snapshot_valid}, 32'b100000);
    chk("midrst_tc_step", {8'd0, train_count, eq_step_size}, 32'd0);
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    tick();
    chk("start_abort_idle", {28'd0, state_out, eq_training_mode}, 32'd0);

    tick();
    chk("state_q_empty", exp_state_q.size(), 32'd0);
    chk("wr_q_empty", exp_wr_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/eq_training_sequencer.md
Name: eq_training_sequencer

Overview:
Sequences training of the adaptive_equalizer through a two-gear LMS schedule: coarse step, then fine step, then a hold period while the equalizer reports convergence. It then freezes the coefficients and snapshots all taps into a local bank through the equalizer's coefficient port. The bank can later be written back through the same port, for example after a head or zone change. It sits between the control/status register block and the equalizer, and owns the equalizer's training_mode, freeze_coefs, step_size and coefficient-access inputs.

Parameters:
NUM_TAPS, 11, equalizer tap count (at most 16)
COEF_WIDTH, 16, coefficient width
RD_LAT, 2, cycles from eq_coef_read/addr asserted to eq_coef_rdata valid
HOLD_SAMPLES, 32, consecutive converged samples required before freeze

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
start  in  1  pulse: begin training (accepted in IDLE, DONE, FAIL)
abort  in  1  pulse: stop training, go to FAIL
restore_req  in  1  pulse: write snapshot back (accepted in IDLE, DONE, FAIL when snapshot_valid)
sample_valid  in  1  mirror of equalizer data_valid; all sample counters advance on this
eq_error_power  in  16  equalizer error power
eq_converged  in  1  equalizer converged flag
eq_coef_rdata  in  COEF_WIDTH  equalizer coefficient read data
eq_training_mode  out  1  to equalizer
eq_freeze_coefs  out  1  to equalizer
eq_step_size  out  8  to equalizer
eq_coef_read  out  1  to equalizer
eq_coef_write  out  1  to equalizer
eq_coef_addr  out  4  to equalizer
eq_coef_wdata  out  COEF_WIDTH  to equalizer
cfg_step_coarse  in  8  coarse step size
cfg_step_fine  in  8  fine step size
cfg_coarse_len  in  16  maximum samples spent in COARSE
cfg_power_thresh  in  16  early gear shift when eq_error_power < thresh
cfg_max_samples  in  16  FINE/HOLD timeout in samples (0 = no timeout)
busy  out  1  high in any state other than IDLE, DONE, FAIL
done  out  1  sticky; cleared on start
fail  out  1  sticky; cleared on start
snapshot_valid  out  1  bank holds a complete snapshot
state_out  out  3  encoding: IDLE=0 COARSE=1 FINE=2 HOLD=3 SNAP=4 DONE=5 FAIL=6 RESTORE=7
train_count  out  16  samples since start, saturating at 0xFFFF

Behaviour:
- Reset values:
  - state IDLE, eq_training_mode=0, eq_freeze_coefs=1, eq_step_size=0.
  - eq_coef_read=0, eq_coef_write=0, eq_coef_addr=0, eq_coef_wdata=0.
  - busy=0, done=0, fail=0, snapshot_valid=0, train_count=0.
  - Bank contents are don't-care.
- All outputs are registered.
- Reset mid-operation returns to IDLE next edge with reset values. Any in-flight coefficient access is dropped.
- Freeze/training by state:
  - eq_freeze_coefs=1 in every state except COARSE, FINE and HOLD.
  - eq_training_mode=1 only in COARSE, FINE and HOLD.
- Accepting start:
  - Load eq_step_size=cfg_step_coarse, clear done, fail and train_count, then enter COARSE.
  - The equalizer sees training_mode=1 and freeze=0 on the cycle after the start pulse.
- COARSE:
  - Count sample_valid.
  - Go to FINE when the count reaches cfg_coarse_len, or when sample_valid is high with eq_error_power < cfg_power_thresh, whichever comes first.
  - On entry to FINE, eq_step_size=cfg_step_fine and the phase counter clears.
- FINE:
  - On sample_valid with eq_converged=1, go to HOLD with hold count=1.
- HOLD:
  - sample_valid with eq_converged=0 returns to FINE and clears the hold count.
  - When the hold count reaches HOLD_SAMPLES, go to SNAP.
- Timeout:
  - A counter of samples in FINE+HOLD; at cfg_max_samples (nonzero), go to FAIL.
  - If timeout and the final hold sample coincide, SNAP wins.
- SNAP:
  - Freeze is already 1 on SNAP entry; snapshot_valid clears on entry.
  - For addr 0..NUM_TAPS-1: assert eq_coef_read=1 with eq_coef_addr=addr and hold both for RD_LAT cycles, then capture eq_coef_rdata into bank[addr].
  - Reads are sequential, one tap at a time. Total SNAP duration is NUM_TAPS*(RD_LAT+1) cycles, including one gap cycle with read=0 between taps.
  - After the last tap: snapshot_valid=1, done=1, go to DONE.
- RESTORE:
  - For each addr, drive one cycle with eq_coef_write=1, eq_coef_addr=addr, eq_coef_wdata=bank[addr], followed by one idle cycle.
  - Then return to the state RESTORE was entered from (IDLE, DONE or FAIL).
  - done and fail are unchanged.
  - restore_req with snapshot_valid=0 is ignored.
- Priority:
  - abort > restore_req > start on the same cycle.
  - abort is honoured in COARSE, FINE, HOLD and SNAP: go to FAIL with fail=1.
  - An aborted SNAP leaves snapshot_valid=0.
  - abort in RESTORE is ignored; restore completes atomically.
- Pulses in non-accepting states are ignored. start during busy is ignored.
- FAIL: freeze=1, training=0, eq_step_size held.
- train_count increments on every sample_valid in COARSE, FINE and HOLD, and saturates.
- eq_coef_read and eq_coef_write are never both 1.

Test Plan:
- Reset with all inputs 0 → eq_freeze_coefs=1, state_out=0, busy=0, snapshot_valid=0; pulse start → next cycle eq_training_mode=1, eq_step_size=cfg_step_coarse (16).
- cfg_coarse_len=20, cfg_power_thresh=0, 20 sample_valid pulses → state_out=2 and eq_step_size=cfg_step_fine (4) after the 20th pulse.
- eq_error_power=10 with cfg_power_thresh=50 on the 3rd sample → FINE after 3 samples.
- FINE with eq_converged=1 for 31 samples, 0 once, then 32 consecutive → SNAP entered only after the final 32; bank matches a model returning 0x1000+addr with 2-cycle latency; done=1 and snapshot_valid=1 after 11*3 cycles.
- cfg_max_samples=100 with eq_converged=0 throughout → fail=1, state_out=6, eq_freeze_coefs=1 after 100 FINE samples.
- restore_req in DONE → 11 eq_coef_write pulses, addr 0..10, wdata=0x1000..0x100A, then back in DONE; abort during SNAP → FAIL, snapshot_valid=0; start and abort on the same cycle in IDLE → no state change; abort during RESTORE → ignored.
